// File: rtl/bcd_disp_pkg.sv
// Shared seven-segment constants, decode function and load-FSM state type
// for the multiplexed BCD display controller.
package bcd_disp_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {IDLE, CONV} ld_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd11.sv
// Combinational 11-bit binary to 4-digit BCD converter (shift-and-add-3).
module bcd11 (
    input  logic [10:0] bin,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones
);

    logic [15:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 10; i >= 0; i--) begin
            for (int j = 0; j < 4; j++) begin
                if (acc[4*j +: 4] >= 4'd5)
                    acc[4*j +: 4] = acc[4*j +: 4] + 4'd3;
            end
            acc = {acc[14:0], bin[i]};
        end
    end

    assign thousands = acc[15:12];
    assign hundreds  = acc[11:8];
    assign tens      = acc[7:4];
    assign ones      = acc[3:0];

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Accepts a binary value over valid/ready, converts it to BCD and scans the
// four digits onto a multiplexed active-low seven-segment display.
module bcd_scan_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter bit BLANK   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [10:0] in_data,
    output logic        in_ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    ld_state_t        state_reg;
    logic [10:0]      in_reg;
    logic             in_ready_reg;
    logic [3:0]       disp_thousands_reg;
    logic [3:0]       disp_hundreds_reg;
    logic [3:0]       disp_tens_reg;
    logic [3:0]       disp_ones_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       slot_reg;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;

    logic [3:0]  conv_thousands, conv_hundreds, conv_tens, conv_ones;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  cur_digit;

    bcd11 u_bcd11 (
        .bin       (in_reg),
        .thousands (conv_thousands),
        .hundreds  (conv_hundreds),
        .tens      (conv_tens),
        .ones      (conv_ones)
    );

    // Load FSM: one value every two cycles, source holds data until ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            in_reg             <= '0;
            in_ready_reg       <= 1'b1;
            disp_thousands_reg <= '0;
            disp_hundreds_reg  <= '0;
            disp_tens_reg      <= '0;
            disp_ones_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        in_reg       <= in_data;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    disp_thousands_reg <= conv_thousands;
                    disp_hundreds_reg  <= conv_hundreds;
                    disp_tens_reg      <= conv_tens;
                    disp_ones_reg      <= conv_ones;
                    in_ready_reg       <= 1'b1;
                    state_reg          <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            slot_reg    <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            slot_reg    <= slot_reg + 2'd1;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign digits = {disp_thousands_reg, disp_hundreds_reg, disp_tens_reg, disp_ones_reg};

    // A digit is blank when it and everything above it is zero; ones never blanks
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = BLANK && (digits[15:4*gi] == '0);
        end
    endgenerate

    assign cur_digit = digits[4*slot_reg +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_OFF;
        end else if (blank[slot_reg]) begin
            an_reg  <= 4'b1111;
            seg_reg <= SEG_OFF;
        end else begin
            an_reg  <= ~(4'b0001 << slot_reg);
            seg_reg <= bcd_to_seg(cur_digit);
        end
    end

    assign in_ready = in_ready_reg;
    assign an       = an_reg;
    assign seg      = seg_reg;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed, table-driven bench for bcd_scan_ctrl with CLK_DIV=4; a second
// instance with BLANK=0 runs on the same stimulus.
module tb_bcd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [10:0] in_data;
    logic        in_ready, in_ready_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct packed {
        logic [10:0] val;
        logic [15:0] an_exp;    // {slot3,slot2,slot1,slot0}, BLANK=1
        logic [27:0] seg_exp;   // {slot3,slot2,slot1,slot0}, BLANK=1
        logic [27:0] segnb_exp; // {slot3,slot2,slot1,slot0}, BLANK=0
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    bcd_scan_ctrl #(.CLK_DIV(4), .BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .an(an), .seg(seg), .dp(dp)
    );

    bcd_scan_ctrl #(.CLK_DIV(4), .BLANK(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_nb), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    // Edges since reset release: output after edge n shows slot ((n-1)/4)%4
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_display(input vec_t v, input string tag);
        bit found = 0;
        logic [3:0] onehot;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (cyc % 16 == 1) begin
                found = 1;
                break;
            end
        end
        check({tag, " slot0_align"}, {31'd0, found}, 32'd1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                int k = i / 4;
                onehot = 4'b0001 << k;
                check($sformatf("%s c%0d an", tag, i), {28'd0, an}, {28'd0, v.an_exp[4*k +: 4]});
                check($sformatf("%s c%0d seg", tag, i), {25'd0, seg}, {25'd0, v.seg_exp[7*k +: 7]});
                check($sformatf("%s c%0d an_nb", tag, i), {28'd0, an_nb}, {28'd0, ~onehot});
                check($sformatf("%s c%0d seg_nb", tag, i), {25'd0, seg_nb}, {25'd0, v.segnb_exp[7*k +: 7]});
                if (i < 15) @(negedge clk);
            end
            check({tag, " dp"}, {31'd0, dp}, 32'd1);
        end
        $display("display %s value=%0d checked", tag, v.val);
    endtask

    task automatic load(input logic [10:0] value);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = value;
        for (int w = 0; w < 10; w++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("load %0d ready_wait", value), {31'd0, ok}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("load %0d ready_low", value), {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check($sformatf("load %0d ready_high", value), {31'd0, in_ready}, 32'd1);
        $display("load value=%0d", value);
    endtask

    initial begin
        vecs[0] = '{11'd0,    {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[1] = '{11'd1234, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[2] = '{11'd2047, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h24, 7'h40, 7'h19, 7'h78}, {7'h24, 7'h40, 7'h19, 7'h78}};
        vecs[3] = '{11'd5,    {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[4] = '{11'd1000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h79, 7'h40, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{11'd10,   {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {7'h7F, 7'h7F, 7'h79, 7'h40}, {7'h40, 7'h40, 7'h79, 7'h40}};
        vecs[6] = '{11'd999,  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'h10, 7'h10, 7'h10}, {7'h40, 7'h10, 7'h10, 7'h10}};
        vecs[7] = '{11'd876,  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'h00, 7'h78, 7'h02}, {7'h40, 7'h00, 7'h78, 7'h02}};
        vecs[8] = '{11'd102,  {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'h79, 7'h40, 7'h24}, {7'h40, 7'h79, 7'h40, 7'h24}};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset an", {28'd0, an}, 32'hF);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset dp", {31'd0, dp}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check_display(vecs[0], "zero");

        for (int i = 1; i < 8; i++) begin
            load(vecs[i].val);
            check_display(vecs[i], $sformatf("vec%0d", i));
        end

        // Held valid with changing data: only alternate cycles are accepted
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 11'd100;
        @(negedge clk);
        check("held ready0", {31'd0, in_ready}, 32'd0);
        in_data = 11'd101;
        @(negedge clk);
        check("held ready1", {31'd0, in_ready}, 32'd1);
        in_data = 11'd102;
        @(negedge clk);
        check("held ready2", {31'd0, in_ready}, 32'd0);
        in_data = 11'd103;
        @(negedge clk);
        check("held ready3", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        $display("held-valid stream 100..103 applied");
        check_display(vecs[8], "held");

        // Asynchronous reset in the middle of slot 2 of a 1234 display
        load(11'd1234);
        begin
            bit hit = 0;
            for (int w = 0; w < 40; w++) begin
                @(negedge clk);
                if (cyc % 16 == 10 && cyc > 2) begin
                    hit = 1;
                    break;
                end
            end
            check("async pre slot2", {31'd0, hit}, 32'd1);
        end
        check("async pre an", {28'd0, an}, 32'hB);
        check("async pre seg", {25'd0, seg}, 32'h24);
        #1 rst = 1'b1;
        #1;
        check("async an", {28'd0, an}, 32'hF);
        check("async seg", {25'd0, seg}, 32'h7F);
        check("async in_ready", {31'd0, in_ready}, 32'd1);
        check("async an_nb", {28'd0, an_nb}, 32'hF);
        $display("async reset asserted mid-slot");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_display(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
